boid_frame_scheduler: RTL and testbench

Sequences the per-frame update of the double-buffered boid display memory.
- On each screen-end event it swaps buffers, then walks every BPU via a select index.
- For each boid it issues one pixel write to the back buffer, then pulses a step strobe so the BPUs advance.
- Sits between the VGA controller's screen_end_out, the BPU output mux and the display RAM write port.

---
 rtl/boid_pkg.sv | 28 ++
 rtl/edge_detect_sync.sv | 23 ++
 rtl/boid_frame_scheduler.sv | 144 ++++++++++++++
 tb/tb_boid_frame_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boid_pkg.sv
// Shared constants and types for the boid display path.
// The wrapper, VGA controller and frame scheduler all import this package.
package boid_pkg;

  localparam int unsigned VIDEO_WIDTH         = 32'd640;
  localparam int unsigned VIDEO_HEIGHT        = 32'd480;
  localparam int unsigned PIXEL_COUNT         = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int unsigned PIXEL_ADDRESS_WIDTH = 32'd19;
  localparam int unsigned MAX_BOIDS           = 32'd64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWAP  = 2'd1,
    ST_WRITE = 2'd2,
    ST_STEP  = 2'd3
  } sched_state_e;

  // Addresses at or beyond the visible area are dropped rather than wrapped.
  function automatic logic addr_in_frame(input logic [PIXEL_ADDRESS_WIDTH-1:0] addr,
                                         input int unsigned                    limit);
    logic [32:0] addr_ext;
    logic [32:0] limit_ext;
    addr_ext  = 33'(addr);
    limit_ext = 33'(limit);
    return (addr_ext < limit_ext);
  endfunction

endpackage

// File: rtl/edge_detect_sync.sv
// Synchronous rising-edge detector; the history register resets to 1 so a
// level already high when reset releases is not reported as an edge.
module edge_detect_sync (
  input  logic clock,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // History register for the sampled level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sig_q <= 1'b1;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/boid_frame_scheduler.sv
// Per-frame sequencer for the double-buffered boid display: swap buffers,
// plot one pixel per BPU into the back buffer, then strobe the BPUs to step.
module boid_frame_scheduler #(
  parameter int unsigned NUM_BOIDS   = 32'd8,
  parameter int unsigned SEL_WIDTH   = $clog2(NUM_BOIDS),
  parameter int unsigned ADDR_WIDTH  = 32'd19,
  parameter int unsigned PIXEL_COUNT = 32'd307200,
  parameter int unsigned FCNT_WIDTH  = 32'd16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  screen_end,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] boid_addr,
  output logic [SEL_WIDTH-1:0]  boid_sel,
  output logic                  pix_we,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  output logic                  buf_swap,
  output logic                  front_buf,
  output logic                  bpu_step,
  output logic                  busy,
  output logic [FCNT_WIDTH-1:0] frame_count,
  output logic                  overrun
);

  import boid_pkg::*;

  localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_BOIDS - 32'd1);

  sched_state_e          state_q, state_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  front_q, front_d;
  logic                  swap_q, swap_d;
  logic                  step_q, step_d;
  logic                  busy_q, busy_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic                  overrun_q, overrun_d;
  logic                  event_s;
  logic                  in_range_s;

  edge_detect_sync u_screen_end_edge (
    .clock  (clock),
    .reset  (reset),
    .sig_i  (screen_end),
    .rise_o (event_s)
  );

  assign in_range_s = ({1'b0, boid_addr} < (ADDR_WIDTH + 1)'(PIXEL_COUNT));

  // Next-state and next-output logic; pulse outputs are decoded from the
  // next state so they line up with the state they belong to.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    front_d   = front_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    fcnt_d    = fcnt_q;
    overrun_d = overrun_q;

    if (event_s && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (event_s && enable) begin
          state_d = ST_SWAP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SWAP: begin
        front_d = ~front_q;
        sel_d   = {SEL_WIDTH{1'b0}};
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        we_d   = in_range_s;
        addr_d = boid_addr;
        if (sel_q == LAST_SEL) begin
          sel_d   = {SEL_WIDTH{1'b0}};
          state_d = ST_STEP;
        end else begin
          sel_d   = sel_q + {{(SEL_WIDTH-1){1'b0}}, 1'b1};
          state_d = ST_WRITE;
        end
      end
      ST_STEP: begin
        fcnt_d  = fcnt_q + {{(FCNT_WIDTH-1){1'b0}}, 1'b1};
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    swap_d = (state_d == ST_SWAP);
    step_d = (state_d == ST_STEP);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= {SEL_WIDTH{1'b0}};
      front_q   <= 1'b0;
      swap_q    <= 1'b0;
      step_q    <= 1'b0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= {ADDR_WIDTH{1'b0}};
      fcnt_q    <= {FCNT_WIDTH{1'b0}};
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      front_q   <= front_d;
      swap_q    <= swap_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      fcnt_q    <= fcnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign boid_sel    = sel_q;
  assign pix_we      = we_q;
  assign pix_addr    = addr_q;
  assign buf_swap    = swap_q;
  assign front_buf   = front_q;
  assign bpu_step    = step_q;
  assign busy        = busy_q;
  assign frame_count = fcnt_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Directed bench for boid_frame_scheduler: pixel writes are checked against a
// scoreboard queue filled when each frame is launched.
module tb_boid_frame_scheduler;

  logic        clock;
  logic        reset;
  logic        screen_end;
  logic        enable;
  logic [18:0] boid_addr;
  logic [2:0]  boid_sel;
  logic        pix_we;
  logic [18:0] pix_addr;
  logic        buf_swap;
  logic        front_buf;
  logic        bpu_step;
  logic        busy;
  logic [15:0] frame_count;
  logic        overrun;

  logic [18:0] boid_addr_b;
  logic [2:0]  boid_sel_b;
  logic        pix_we_b;
  logic [18:0] pix_addr_b;
  logic        buf_swap_b;
  logic        front_buf_b;
  logic        bpu_step_b;
  logic        busy_b;
  logic [2:0]  frame_count_b;
  logic        overrun_b;

  logic [18:0] addr_tbl [8];
  logic [18:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int n_we   = 0;
  int n_swap = 0;
  int n_step = 0;

  boid_frame_scheduler dut (
    .clock(clock), .reset(reset), .screen_end(screen_end), .enable(enable),
    .boid_addr(boid_addr), .boid_sel(boid_sel), .pix_we(pix_we), .pix_addr(pix_addr),
    .buf_swap(buf_swap), .front_buf(front_buf), .bpu_step(bpu_step), .busy(busy),
    .frame_count(frame_count), .overrun(overrun)
  );

  // Narrow frame counter instance, used to observe the wrap.
  boid_frame_scheduler #(.FCNT_WIDTH(3)) dut_b (
    .clock(clock), .reset(reset), .screen_end(screen_end), .enable(enable),
    .boid_addr(boid_addr_b), .boid_sel(boid_sel_b), .pix_we(pix_we_b), .pix_addr(pix_addr_b),
    .buf_swap(buf_swap_b), .front_buf(front_buf_b), .bpu_step(bpu_step_b), .busy(busy_b),
    .frame_count(frame_count_b), .overrun(overrun_b)
  );

  assign boid_addr   = addr_tbl[boid_sel];
  assign boid_addr_b = addr_tbl[boid_sel_b];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse();
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic set_tbl(input int base);
    for (int i = 0; i < 8; i++) addr_tbl[i] = 19'(base + i);
  endtask

  task automatic push_tbl(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(19'(base + i));
  endtask

  task automatic clear_counts();
    n_we = 0;
    n_swap = 0;
    n_step = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    32'(pix_we),      32'd0);
    chk({tag, "_addr"},  32'(pix_addr),    32'd0);
    chk({tag, "_swap"},  32'(buf_swap),    32'd0);
    chk({tag, "_step"},  32'(bpu_step),    32'd0);
    chk({tag, "_busy"},  32'(busy),        32'd0);
    chk({tag, "_front"}, 32'(front_buf),   32'd0);
    chk({tag, "_fcnt"},  32'(frame_count), 32'd0);
    chk({tag, "_ovr"},   32'(overrun),     32'd0);
    chk({tag, "_sel"},   32'(boid_sel),    32'd0);
  endtask

  // Output monitor: pulse counters, exclusivity, and scoreboard pops.
  always @(negedge clock) begin
    logic [18:0] e;
    if (buf_swap === 1'b1) n_swap++;
    if (bpu_step === 1'b1) n_step++;
    chk("swap_exclusive", 32'(buf_swap & (bpu_step | pix_we)), 32'd0);
    if (pix_we === 1'b1) begin
      n_we++;
      chk("sb_unexpected_write", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_addr", 32'(pix_addr), 32'(e));
      end
    end
  end

  initial begin
    reset = 1'b1;
    screen_end = 1'b1;
    enable = 1'b1;
    set_tbl(1000);
    repeat (3) tick();
    chk_all_zero("reset");

    // Level high at reset release must not start a frame.
    reset = 1'b0;
    clear_counts();
    repeat (6) tick();
    chk("lvl_no_swap", 32'(n_swap), 32'd0);
    chk("lvl_busy", 32'(busy), 32'd0);
    screen_end = 1'b0;
    tick();

    // Basic frame with exact cycle timing.
    push_tbl(1000, 8);
    clear_counts();
    pulse();
    chk("t1_swap", 32'(buf_swap), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_sel", 32'(boid_sel), 32'd0);
    tick();
    chk("t2_front", 32'(front_buf), 32'd1);
    chk("t2_we", 32'(pix_we), 32'd0);
    chk("t2_swap", 32'(buf_swap), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("wr_we", 32'(pix_we), 32'd1);
      chk("wr_addr", 32'(pix_addr), 32'(1000 + k));
    end
    chk("t10_step", 32'(bpu_step), 32'd1);
    tick();
    chk("t11_busy", 32'(busy), 32'd0);
    chk("t11_we", 32'(pix_we), 32'd0);
    chk("t11_step", 32'(bpu_step), 32'd0);
    chk("t11_fcnt", 32'(frame_count), 32'd1);
    chk("t11_nwe", 32'(n_we), 32'd8);

    // Out-of-range address for boid 3 is dropped.
    for (int i = 0; i < 8; i++) addr_tbl[i] = 19'd307199;
    addr_tbl[3] = 19'd307200;
    for (int i = 0; i < 7; i++) exp_q.push_back(19'd307199);
    clear_counts();
    pulse();
    wait_idle("oor_done");
    tick();
    chk("oor_nwe", 32'(n_we), 32'd7);
    chk("oor_q", 32'(exp_q.size()), 32'd0);
    chk("oor_fcnt", 32'(frame_count), 32'd2);

    // Second event during a frame sets overrun and is dropped.
    set_tbl(2000);
    push_tbl(2000, 8);
    clear_counts();
    pulse();
    repeat (4) tick();
    pulse();
    wait_idle("ovr_done");
    repeat (3) tick();
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_nswap", 32'(n_swap), 32'd1);
    chk("ovr_nstep", 32'(n_step), 32'd1);
    chk("ovr_nwe", 32'(n_we), 32'd8);
    chk("ovr_fcnt", 32'(frame_count), 32'd3);

    // Disabled event ignored; disable mid-frame lets the frame finish.
    enable = 1'b0;
    clear_counts();
    pulse();
    repeat (12) tick();
    chk("dis_nswap", 32'(n_swap), 32'd0);
    chk("dis_nwe", 32'(n_we), 32'd0);
    chk("dis_fcnt", 32'(frame_count), 32'd3);
    enable = 1'b1;
    set_tbl(3000);
    push_tbl(3000, 8);
    pulse();
    repeat (3) tick();
    enable = 1'b0;
    wait_idle("mid_done");
    tick();
    chk("mid_nwe", 32'(n_we), 32'd8);
    chk("mid_nstep", 32'(n_step), 32'd1);
    chk("mid_fcnt", 32'(frame_count), 32'd4);
    chk("mid_ovr", 32'(overrun), 32'd1);
    enable = 1'b1;

    // Reset mid-WRITE abandons the frame after four writes.
    set_tbl(4000);
    push_tbl(4000, 4);
    clear_counts();
    pulse();
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk_all_zero("midrst");
    tick();
    reset = 1'b0;
    repeat (12) tick();
    chk("midrst_nstep", 32'(n_step), 32'd0);
    chk("midrst_nwe", 32'(n_we), 32'd4);
    chk("midrst_nswap", 32'(n_swap), 32'd1);
    chk("midrst_q", 32'(exp_q.size()), 32'd0);

    // Frame counter wrap on the 3-bit instance.
    set_tbl(5000);
    for (int f = 0; f < 7; f++) begin
      push_tbl(5000, 8);
      pulse();
      wait_idle("wrap_done");
      tick();
    end
    chk("wrap_pre", 32'(frame_count_b), 32'd7);
    push_tbl(5000, 8);
    pulse();
    wait_idle("wrap_done");
    tick();
    chk("wrap_post", 32'(frame_count_b), 32'd0);
    chk("wrap_wide", 32'(frame_count), 32'd8);
    chk("wrap_q", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
